id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID->EX pipeline register for the RV32I core. It captures the decoded instruction from the
//  decode stage over a valid/ready handshake and resolves operand bypassing from the MEM and WB
//  stages. It selects the A/B operands, translates funct3/funct7 into the 4-bit ALU op code,
//  and presents registered alu_a/alu_b/alu_op to the ALU. Provides stall (backpressure) and flush.
// PARAMETERS
//  XLEN        32  datapath width
//  RA_W        5   register-address width
// PORTS
//  clk          in   1     core clock, rising edge
//  rst_n        in   1     asynchronous active-low reset
//  flush        in   1     kill held + incoming instruction (branch/trap redirect)
//  in_valid     in   1     decode presents an instruction
//  in_ready     out  1     stage can accept this cycle
//  in_pc        in   XLEN  instruction PC
//  in_rs1_data  in   XLEN  regfile read data, rs1
//  in_rs2_data  in   XLEN  regfile read data, rs2
//  in_imm       in   XLEN  sign-extended immediate
//  in_rs1/rs2   in   RA_W  source register addresses
//  in_rd        in   RA_W  destination register
//  in_cls       in   3     instr class: OP=0, OPIMM=1, LUI=2, AUIPC=3, OTHER=4
//  in_funct3    in   3     funct3 field
//  in_f7b5      in   1     instr[30]
//  mem_wen/mem_rd/mem_data  in 1/RA_W/XLEN  MEM-stage bypass source
//  wb_wen/wb_rd/wb_data     in 1/RA_W/XLEN  WB-stage bypass source
//  out_valid    out  1     held instruction valid for EX
//  out_ready    in   1     EX consumes the held instruction
//  alu_a/alu_b  out  XLEN  ALU operands (registered)
//  alu_op       out  4     ALU op code (registered)
//  out_rd       out  RA_W  destination register
//  out_wen      out  1     register write enable (in_rd!=0 and cls!=OTHER)
// BEHAVIOUR
//  - Reset: out_valid=0 and every other output register=0. in_ready=1 after reset.
//  - in_ready = !out_valid | out_ready (combinational). Transfer occurs when in_valid & in_ready.
//  - Latency: 1 cycle. Data accepted at edge N appears on outputs after edge N; it is held
//    stable while out_valid & !out_ready.
//  - Two states: EMPTY (out_valid=0) and FULL (out_valid=1).
//    EMPTY->FULL on accept. FULL->EMPTY when out_ready & !in_valid. FULL->FULL on a simultaneous
//    consume + accept (back-to-back; no bubble).
//  - flush has the highest priority. At the edge, out_valid<=0 and any incoming instruction is
//    dropped. Data registers may keep stale values.
//  - Bypass is evaluated per source register. If the address is 0, the operand is 0.
//    Else if mem_wen & mem_rd==rs, use mem_data (MEM beats WB). Else if wb_wen & wb_rd==rs,
//    use wb_data. Else use the regfile data.
//  - Bypass also applies to the held entry while stalled. Each FULL & !out_ready cycle, the
//    stage stores rs1/rs2 and re-resolves alu_a/alu_b against mem/wb. The updated value is
//    visible the next cycle.
//  - Operand A: OP/OPIMM -> rs1 value; LUI -> 0; AUIPC -> in_pc; OTHER -> rs1 value.
//    Operand B: OP -> rs2 value; OPIMM/LUI/AUIPC -> imm; OTHER -> rs2 value.
//    For shift ops, B is masked to B[4:0] zero-extended.
//  - alu_op decode (package constants). funct3 000 -> ADD, or SUB when cls==OP & f7b5.
//    001 -> SLL. 010 -> SLT. 011 -> SLTU. 100 -> XOR.
//    101 -> SRL, or SRA when f7b5 (both OP and OPIMM). 110 -> OR. 111 -> AND.
//    LUI/AUIPC/OTHER -> ADD.
//  - Async reset mid-stall clears out_valid immediately. The pending instruction is lost.
// STRUCTURE
//  - Package core_pkg: ALU_ADD=4'h0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8,
//    SLTU=9; the instr-class encodings.
//  - Sub-module fwd_mux: one instance per source; combinational bypass select.
//  - The rest (handshake FSM, op decode, operand regs) stays in this module.
// TESTING
//  1. Reset: rst_n low mid-FULL -> out_valid=0, alu_a/b/op=0 at once; in_ready=1.
//  2. cls=OP, f3=000, f7b5=1, rs1=5 (100), rs2=6 (30) -> next cycle alu_op=SUB, a=100, b=30.
//  3. Bypass priority: rs1=7, mem_wen with mem_rd=7 data=0xAA, wb_wen with wb_rd=7 data=0xBB
//     -> alu_a=0xAA. rs1=0 with both bypasses at rd=0 -> alu_a=0.
//  4. Stall refresh: hold out_ready=0 for 3 cycles. wb writes rs2=9 data=0x55 in cycle 2
//     -> alu_b=0x55 from cycle 3. Outputs are otherwise stable.
//  5. OPIMM SRAI: imm=0x0000_0403, f3=101, f7b5=1 -> alu_op=SRA, alu_b=3.
//     AUIPC pc=0x100 imm=0x2000 -> a=0x100, b=0x2000, ADD.
//  6. Back-to-back: in_valid and out_ready high for 4 cycles -> 4 transfers with no bubble.
//     flush in cycle 2 -> that instruction is dropped and out_valid=0 the next cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: ALU op codes, instruction classes and the
// funct3/funct7 to ALU op translation used by the ID->EX stage.
package core_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;

    typedef enum logic [2:0] {
        CLS_OP    = 3'd0,
        CLS_OPIMM = 3'd1,
        CLS_LUI   = 3'd2,
        CLS_AUIPC = 3'd3,
        CLS_OTHER = 3'd4
    } cls_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

    // Only register/immediate arithmetic classes look at funct3; everything else adds.
    function automatic logic [3:0] decode_alu_op(input logic [2:0] cls,
                                                 input logic [2:0] funct3,
                                                 input logic       f7b5);
        logic [3:0] op;
        op = ALU_ADD;
        if (cls == CLS_OP || cls == CLS_OPIMM) begin
            case (funct3)
                3'b000:  op = (cls == CLS_OP && f7b5) ? ALU_SUB : ALU_ADD;
                3'b001:  op = ALU_SLL;
                3'b010:  op = ALU_SLT;
                3'b011:  op = ALU_SLTU;
                3'b100:  op = ALU_XOR;
                3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
                3'b110:  op = ALU_OR;
                default: op = ALU_AND;
            endcase
        end
        return op;
    endfunction

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Combinational operand bypass for one source register: x0 reads zero,
// MEM-stage result beats WB-stage result, otherwise the supplied base value.
module fwd_mux #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic            mem_wen,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_wen,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] value
);

    always_comb begin
        value = rf_data;
        if (rs == '0) begin
            value = '0;
        end else if (mem_wen && mem_rd == rs) begin
            value = mem_data;
        end else if (wb_wen && wb_rd == rs) begin
            value = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: valid/ready handshake, operand bypass and select,
// ALU op decode, with registered operands that keep tracking bypasses while stalled.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [RA_W-1:0] in_rs1,
    input  logic [RA_W-1:0] in_rs2,
    input  logic [RA_W-1:0] in_rd,
    input  logic [2:0]      in_cls,
    input  logic [2:0]      in_funct3,
    input  logic            in_f7b5,
    input  logic            mem_wen,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_wen,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic [RA_W-1:0] out_rd,
    output logic            out_wen
);

    stage_state_e    state_reg, state_next;
    logic            accept;
    logic            stall;
    logic [RA_W-1:0] rs1_reg, rs2_reg;
    logic            a_uses_rs1_reg, b_uses_rs2_reg;

    logic [RA_W-1:0] src_sel [2];
    logic [XLEN-1:0] src_rf  [2];
    logic [XLEN-1:0] src_val [2];

    logic            in_is_other;
    logic [3:0]      op_next;
    logic [XLEN-1:0] a_next, b_sel, b_next, b_refresh;

    assign stall  = (state_reg == ST_FULL) && !out_ready;
    assign accept = in_valid && in_ready && !flush;

    // ---------------- handshake FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: if (in_valid) state_next = ST_FULL;
                ST_FULL:  if (out_ready && !in_valid) state_next = ST_EMPTY;
                default:  state_next = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_reg == ST_FULL);
        in_ready  = (state_reg != ST_FULL) || out_ready;
    end

    // While stalled, the bypass muxes re-resolve the held operands instead of the incoming ones.
    always_comb begin
        src_sel[0] = stall ? rs1_reg : in_rs1;
        src_sel[1] = stall ? rs2_reg : in_rs2;
        src_rf[0]  = stall ? alu_a   : in_rs1_data;
        src_rf[1]  = stall ? alu_b   : in_rs2_data;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd (
                .rs       (src_sel[gi]),
                .rf_data  (src_rf[gi]),
                .mem_wen  (mem_wen),
                .mem_rd   (mem_rd),
                .mem_data (mem_data),
                .wb_wen   (wb_wen),
                .wb_rd    (wb_rd),
                .wb_data  (wb_data),
                .value    (src_val[gi])
            );
        end
    endgenerate

    // ---------------- operand select and op decode ----------------
    always_comb begin
        in_is_other = !(in_cls == CLS_OP || in_cls == CLS_OPIMM ||
                        in_cls == CLS_LUI || in_cls == CLS_AUIPC);
        op_next     = decode_alu_op(in_cls, in_funct3, in_f7b5);

        case (in_cls)
            CLS_LUI:   a_next = '0;
            CLS_AUIPC: a_next = in_pc;
            default:   a_next = src_val[0];
        endcase

        b_sel  = (in_cls == CLS_OP || in_is_other) ? src_val[1] : in_imm;
        b_next = is_shift_op(op_next) ? {{(XLEN-5){1'b0}}, b_sel[4:0]} : b_sel;

        b_refresh = is_shift_op(alu_op) ? {{(XLEN-5){1'b0}}, src_val[1][4:0]} : src_val[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a          <= '0;
            alu_b          <= '0;
            alu_op         <= ALU_ADD;
            out_rd         <= '0;
            out_wen        <= 1'b0;
            rs1_reg        <= '0;
            rs2_reg        <= '0;
            a_uses_rs1_reg <= 1'b0;
            b_uses_rs2_reg <= 1'b0;
        end else if (accept) begin
            alu_a          <= a_next;
            alu_b          <= b_next;
            alu_op         <= op_next;
            out_rd         <= in_rd;
            out_wen        <= (in_rd != '0) && !in_is_other;
            rs1_reg        <= in_rs1;
            rs2_reg        <= in_rs2;
            a_uses_rs1_reg <= !(in_cls == CLS_LUI || in_cls == CLS_AUIPC);
            b_uses_rs2_reg <= (in_cls == CLS_OP) || in_is_other;
        end else if (stall) begin
            // Only operands that came from a register can be overtaken by a later writer.
            if (a_uses_rs1_reg) alu_a <= src_val[0];
            if (b_uses_rs2_reg) alu_b <= b_refresh;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a table of single-transfer vectors plus
// hand-written stall-refresh, back-to-back/flush and reset sequences.
module tb_id_ex_stage;

    localparam logic [3:0] E_ADD = 4'h0, E_SUB = 4'h1, E_AND = 4'h2, E_OR  = 4'h3, E_XOR = 4'h4;
    localparam logic [3:0] E_SLL = 4'h5, E_SRL = 4'h6, E_SRA = 4'h7, E_SLT = 4'h8, E_SLTU = 4'h9;
    localparam int NV = 18;

    typedef struct {
        logic [2:0]  cls;
        logic [2:0]  f3;
        logic        f7b5;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm, pc;
        logic        mw;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic [31:0] ea, eb;
        logic [3:0]  eop;
        logic        ewen;
    } vec_t;

    logic        clk, rst_n, flush, in_valid, in_ready, in_f7b5;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm, mem_data, wb_data, alu_a, alu_b;
    logic [4:0]  in_rs1, in_rs2, in_rd, mem_rd, wb_rd, out_rd;
    logic [2:0]  in_cls, in_funct3;
    logic        mem_wen, wb_wen, out_valid, out_ready, out_wen;
    logic [3:0]  alu_op;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs [NV];

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_cls(in_cls), .in_funct3(in_funct3),
        .in_f7b5(in_f7b5), .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid),
        .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .out_rd(out_rd), .out_wen(out_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] cls, f3, f7b5, rs1, rs2, rd, d1, d2, imm, pc,
                                mw, mrd, mdat, ww, wrd, wdat, ea, eb, eop, ewen);
        vec_t v;
        v.cls = 3'(cls);   v.f3 = 3'(f3);     v.f7b5 = f7b5[0];
        v.rs1 = 5'(rs1);   v.rs2 = 5'(rs2);   v.rd = 5'(rd);
        v.d1 = d1; v.d2 = d2; v.imm = imm; v.pc = pc;
        v.mw = mw[0]; v.mrd = 5'(mrd); v.mdat = mdat;
        v.ww = ww[0]; v.wrd = 5'(wrd); v.wdat = wdat;
        v.ea = ea; v.eb = eb; v.eop = 4'(eop); v.ewen = ewen[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_cls = v.cls; in_funct3 = v.f3; in_f7b5 = v.f7b5;
        in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd;
        in_rs1_data = v.d1; in_rs2_data = v.d2; in_imm = v.imm; in_pc = v.pc;
        mem_wen = v.mw; mem_rd = v.mrd; mem_data = v.mdat;
        wb_wen = v.ww; wb_rd = v.wrd; wb_data = v.wdat;
    endtask

    task automatic clear_bypass();
        mem_wen = 1'b0; mem_rd = '0; mem_data = '0;
        wb_wen = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    initial begin
        //         cls f3 f7 rs1 rs2 rd d1           d2           imm          pc     mw mrd mdat   ww wrd wdat   ea           eb           op     wen
        vecs[0]  = mk(0, 0, 1, 5,  6,  1, 100,         30,          0,           0,     0, 0,  0,     0, 0,  0,     100,         30,          E_SUB, 1);
        vecs[1]  = mk(0, 0, 0, 7,  8,  2, 'h11,        'h22,        0,           0,     1, 7,  'hAA,  1, 7,  'hBB,  'hAA,        'h22,        E_ADD, 1);
        vecs[2]  = mk(0, 0, 0, 0,  0,  3, 'h33,        'h44,        0,           0,     1, 0,  'hAA,  1, 0,  'hBB,  0,           0,           E_ADD, 1);
        vecs[3]  = mk(0, 4, 0, 4,  4,  4, 1,           2,           0,           0,     0, 4,  'hAA,  1, 4,  'hBB,  'hBB,        'hBB,        E_XOR, 1);
        vecs[4]  = mk(1, 5, 1, 2,  3,  5, 'h8000_0000, 'h99,        'h403,       0,     0, 0,  0,     0, 0,  0,     'h8000_0000, 3,           E_SRA, 1);
        vecs[5]  = mk(3, 0, 0, 1,  2,  6, 'hDEAD,      'hBEEF,      'h2000,      'h100, 0, 0,  0,     0, 0,  0,     'h100,       'h2000,      E_ADD, 1);
        vecs[6]  = mk(2, 0, 0, 1,  2,  7, 'hDEAD,      'hBEEF,      'h1234_5000, 'h200, 0, 0,  0,     0, 0,  0,     0,           'h1234_5000, E_ADD, 1);
        vecs[7]  = mk(0, 5, 0, 10, 11, 8, 'h1234,      'hFFFF_FFE7, 0,           0,     0, 0,  0,     0, 0,  0,     'h1234,      7,           E_SRL, 1);
        vecs[8]  = mk(0, 1, 0, 12, 13, 9, 1,           'h25,        0,           0,     1, 13, 'h3F,  0, 0,  0,     1,           'h1F,        E_SLL, 1);
        vecs[9]  = mk(1, 0, 1, 14, 15, 10, 'h50,       'h60,        'h400,       0,     0, 0,  0,     0, 0,  0,     'h50,        'h400,       E_ADD, 1);
        vecs[10] = mk(0, 2, 0, 16, 17, 11, 5,          6,           0,           0,     0, 0,  0,     0, 0,  0,     5,           6,           E_SLT, 1);
        vecs[11] = mk(1, 3, 0, 18, 19, 12, 7,          8,           'hFFF,       0,     0, 0,  0,     0, 0,  0,     7,           'hFFF,       E_SLTU, 1);
        vecs[12] = mk(1, 6, 0, 20, 21, 13, 9,          'hA,         'hF0,        0,     0, 0,  0,     0, 0,  0,     9,           'hF0,        E_OR,  1);
        vecs[13] = mk(0, 7, 1, 22, 23, 14, 'hB,        'hC,         0,           0,     0, 0,  0,     0, 0,  0,     'hB,         'hC,         E_AND, 1);
        vecs[14] = mk(4, 0, 1, 24, 25, 15, 'hD,        'hE,         'h77,        0,     0, 0,  0,     0, 0,  0,     'hD,         'hE,         E_ADD, 0);
        vecs[15] = mk(0, 0, 0, 26, 27, 0,  1,          2,           0,           0,     0, 0,  0,     0, 0,  0,     1,           2,           E_ADD, 0);
        vecs[16] = mk(1, 5, 0, 28, 29, 16, 'hF0,       'h1,         'h25,        0,     1, 28, 'h100, 0, 0,  0,     'h100,       5,           E_SRL, 1);
        vecs[17] = mk(1, 1, 0, 30, 29, 17, 3,          'h1,         7,           0,     1, 31, 'hCC,  1, 30, 9,     9,           7,           E_SLL, 1);

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(vecs[0]);
        clear_bypass();
        #12;
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset in_ready", 32'(in_ready), 1);
        chk("reset alu_a", alu_a, 0);
        chk("reset alu_op", 32'(alu_op), 0);
        @(negedge clk) rst_n = 1'b1;

        // Table vectors, applied back to back with EX always ready.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            step();
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 1);
            chk($sformatf("vec%0d alu_a", i), alu_a, vecs[i].ea);
            chk($sformatf("vec%0d alu_b", i), alu_b, vecs[i].eb);
            chk($sformatf("vec%0d alu_op", i), 32'(alu_op), 32'(vecs[i].eop));
            chk($sformatf("vec%0d out_rd", i), 32'(out_rd), 32'(vecs[i].rd));
            chk($sformatf("vec%0d out_wen", i), 32'(out_wen), 32'(vecs[i].ewen));
            $display("vec%0d: cls=%0d f3=%0d a=0x%08h b=0x%08h op=%0d", i, vecs[i].cls, vecs[i].f3, alu_a, alu_b, alu_op);
        end
        in_valid = 1'b0;
        clear_bypass();
        step();
        chk("drain out_valid", 32'(out_valid), 0);

        // Stall with bypass refresh of the held entry.
        in_cls = 3'd0; in_funct3 = 3'd0; in_f7b5 = 1'b0;
        in_rs1 = 5'd3; in_rs2 = 5'd9; in_rd = 5'd5;
        in_rs1_data = 32'h10; in_rs2_data = 32'h20;
        in_valid = 1'b1; out_ready = 1'b0;
        step();
        chk("stall load valid", 32'(out_valid), 1);
        chk("stall load in_ready", 32'(in_ready), 0);
        in_valid = 1'b0; in_rs1_data = 32'hFFFF; in_rs2_data = 32'hFFFF; in_rs1 = 5'd1; in_rs2 = 5'd2;
        step();
        chk("stall c1 alu_a", alu_a, 32'h10);
        chk("stall c1 alu_b", alu_b, 32'h20);
        wb_wen = 1'b1; wb_rd = 5'd9; wb_data = 32'h55;
        mem_wen = 1'b1; mem_rd = 5'd3; mem_data = 32'h77;
        step();
        clear_bypass();
        chk("stall c2 alu_b", alu_b, 32'h55);
        chk("stall c2 alu_a", alu_a, 32'h77);
        chk("stall c2 alu_op", 32'(alu_op), 32'(E_ADD));
        step();
        chk("stall c3 alu_b", alu_b, 32'h55);
        chk("stall c3 out_rd", 32'(out_rd), 5);
        chk("stall c3 valid", 32'(out_valid), 1);
        $display("stall: a=0x%08h b=0x%08h valid=%0d", alu_a, alu_b, out_valid);
        out_ready = 1'b1;
        step();
        chk("stall release valid", 32'(out_valid), 0);
        chk("stall release in_ready", 32'(in_ready), 1);

        // Back-to-back transfers with a flush on the second one.
        in_rs2 = 5'd0; in_cls = 3'd0; in_funct3 = 3'd0;
        for (int k = 0; k < 4; k++) begin
            in_rs1 = 5'(k + 1); in_rs1_data = 32'(k + 1);
            in_valid = 1'b1; flush = (k == 1);
            step();
            chk($sformatf("b2b%0d out_valid", k), 32'(out_valid), (k == 1) ? 0 : 1);
            chk($sformatf("b2b%0d in_ready", k), 32'(in_ready), 1);
            if (k != 1) chk($sformatf("b2b%0d alu_a", k), alu_a, 32'(k + 1));
            $display("b2b%0d: flush=%0d valid=%0d a=0x%08h", k, flush, out_valid, alu_a);
        end
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("b2b drain valid", 32'(out_valid), 0);

        // Flush of a stalled entry.
        in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush stalled valid", 32'(out_valid), 0);

        // Asynchronous reset while FULL and stalled.
        in_rs1 = 5'd4; in_rs1_data = 32'hABCD; in_rd = 5'd6; in_funct3 = 3'd4;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("pre-reset valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset valid", 32'(out_valid), 0);
        chk("async reset alu_a", alu_a, 0);
        chk("async reset alu_b", alu_b, 0);
        chk("async reset alu_op", 32'(alu_op), 0);
        chk("async reset out_wen", 32'(out_wen), 0);
        chk("async reset in_ready", 32'(in_ready), 1);
        $display("async reset: valid=%0d a=0x%08h op=%0d", out_valid, alu_a, alu_op);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("post-reset valid", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
